// File: rtl/signed_minmax_tracker_if.sv
// Handshake bundle for signed_minmax_tracker: sample input stream plus
// summary record output stream, each with its own valid/ready pair.
interface signed_minmax_tracker_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  // Sample stream
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;

  // Summary record stream
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_min;
  logic signed [DATA_W-1:0] out_max;
  logic [CNT_W-1:0]         out_min_idx;
  logic [CNT_W-1:0]         out_max_idx;
  logic [CNT_W-1:0]         out_count;
  logic                     out_sat;

  // Producer of samples / consumer of records
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max,
           out_min_idx, out_max_idx, out_count, out_sat
  );

  // The tracker itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max,
           out_min_idx, out_max_idx, out_count, out_sat
  );
endinterface

// File: rtl/signed_minmax_tracker.sv
// Streaming signed min/max tracker. Consumes a frame of two's-complement
// samples, keeps the running signed minimum/maximum with the index of their
// first occurrence and a saturating sample count, and presents one summary
// record per frame. All record fields are registers, so they are stable for
// as long as out_valid is held waiting for out_ready.
module signed_minmax_tracker #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  signed_minmax_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Strict signed less-than. Both operands are declared signed, so the
  // comparison is a true two's-complement ordering with no subtraction and
  // therefore no overflow corner (0x8000 < 0x7FFF holds).
  function automatic logic signed_lt(input logic signed [DATA_W-1:0] a,
                                     input logic signed [DATA_W-1:0] b);
    return a < b;
  endfunction

  // Saturating count increment: sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c == CNT_MAX) r = c;
    else              r = c + CNT_ONE;
    return r;
  endfunction

  // True once the counter has hit its ceiling; the next sample overflows it.
  function automatic logic at_sat(input logic [CNT_W-1:0] c);
    return c == CNT_MAX;
  endfunction

  state_t                   state;
  logic signed [DATA_W-1:0] min_p0;
  logic signed [DATA_W-1:0] max_p0;
  logic [CNT_W-1:0]         min_idx_p0;
  logic [CNT_W-1:0]         max_idx_p0;
  logic [CNT_W-1:0]         count_p0;
  logic                     sat_p0;
  logic                     vld_p0;
  logic                     rdy_p0;

  logic                     take;
  logic                     new_min;
  logic                     new_max;

  // A sample transfers only when offered, accepted and not overridden by
  // clear; in_last and in_data are ignored otherwise.
  assign take = bus.in_valid && rdy_p0 && !clear;

  // Strict compares against the running extremes; ties keep the older index.
  always_comb begin
    new_min = 1'b0;
    new_max = 1'b0;
    new_min = signed_lt(bus.in_data, min_p0);
    new_max = signed_lt(max_p0, bus.in_data);
  end

  // Frame FSM with all accumulators and handshake outputs registered.
  // in_ready is a flop, so there is no combinational path from out_ready.
  // The sample index equals the current count; because the count saturates,
  // samples at or past the ceiling are indexed as the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      min_p0     <= '0;
      max_p0     <= '0;
      min_idx_p0 <= CNT_ZERO;
      max_idx_p0 <= CNT_ZERO;
      count_p0   <= CNT_ZERO;
      sat_p0     <= 1'b0;
      vld_p0     <= 1'b0;
      rdy_p0     <= 1'b1;
    end else if (clear) begin
      state      <= IDLE;
      min_p0     <= '0;
      max_p0     <= '0;
      min_idx_p0 <= CNT_ZERO;
      max_idx_p0 <= CNT_ZERO;
      count_p0   <= CNT_ZERO;
      sat_p0     <= 1'b0;
      vld_p0     <= 1'b0;
      rdy_p0     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            min_p0     <= bus.in_data;
            max_p0     <= bus.in_data;
            min_idx_p0 <= CNT_ZERO;
            max_idx_p0 <= CNT_ZERO;
            count_p0   <= CNT_ONE;
            sat_p0     <= 1'b0;
            if (bus.in_last) begin
              state  <= REPORT;
              vld_p0 <= 1'b1;
              rdy_p0 <= 1'b0;
            end else begin
              state  <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (take) begin
            if (new_min) begin
              min_p0     <= bus.in_data;
              min_idx_p0 <= count_p0;
            end
            if (new_max) begin
              max_p0     <= bus.in_data;
              max_idx_p0 <= count_p0;
            end
            count_p0 <= sat_inc(count_p0);
            if (at_sat(count_p0)) begin
              sat_p0 <= 1'b1;
            end
            if (bus.in_last) begin
              state  <= REPORT;
              vld_p0 <= 1'b1;
              rdy_p0 <= 1'b0;
            end
          end
        end

        REPORT: begin
          if (bus.out_ready) begin
            state  <= IDLE;
            vld_p0 <= 1'b0;
            rdy_p0 <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          vld_p0 <= 1'b0;
          rdy_p0 <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = rdy_p0;
  assign bus.out_valid   = vld_p0;
  assign bus.out_min     = min_p0;
  assign bus.out_max     = max_p0;
  assign bus.out_min_idx = min_idx_p0;
  assign bus.out_max_idx = max_idx_p0;
  assign bus.out_count   = count_p0;
  assign bus.out_sat     = sat_p0;

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Self-checking bench for signed_minmax_tracker: expected records are queued
// as each frame is driven and compared when the DUT hands a record over.
module tb_signed_minmax_tracker;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [15:0] mn;
    logic [15:0] mx;
    logic [7:0]  mn_i;
    logic [7:0]  mx_i;
    logic [7:0]  cnt;
    logic        sat;
  } rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  int errors = 0;
  int checks = 0;

  rec_t sb[$];
  rec_t mon_got;
  rec_t mon_exp;

  signed_minmax_tracker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  signed_minmax_tracker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk(input logic [15:0] mn, input logic [15:0] mx,
                              input logic [7:0] mi, input logic [7:0] xi,
                              input logic [7:0] c, input logic s);
    rec_t r;
    r.mn = mn; r.mx = mx; r.mn_i = mi; r.mx_i = xi; r.cnt = c; r.sat = s;
    return r;
  endfunction

  // Reference: scan the whole frame, first strict extreme wins, positions
  // beyond 255 clip to 255, count clips to 255 and sat flags length > 255.
  function automatic rec_t model(input logic [15:0] s[$]);
    rec_t r;
    r.mn = s[0]; r.mx = s[0]; r.mn_i = 8'd0; r.mx_i = 8'd0;
    for (int i = 1; i < s.size(); i++) begin
      if ($signed(s[i]) < $signed(r.mn)) begin
        r.mn = s[i]; r.mn_i = (i > 255) ? 8'd255 : 8'(i);
      end
      if ($signed(s[i]) > $signed(r.mx)) begin
        r.mx = s[i]; r.mx_i = (i > 255) ? 8'd255 : 8'(i);
      end
    end
    r.cnt = (s.size() > 255) ? 8'd255 : 8'(s.size());
    r.sat = (s.size() > 255);
    return r;
  endfunction

  // Record monitor: sampled on the falling edge, a handshake completes at the
  // next rising edge so each record is seen exactly once.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      mon_got.mn   = bus.out_min;
      mon_got.mx   = bus.out_max;
      mon_got.mn_i = bus.out_min_idx;
      mon_got.mx_i = bus.out_max_idx;
      mon_got.cnt  = bus.out_count;
      mon_got.sat  = bus.out_sat;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got=%h required=none", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL record got min=%h max=%h mi=%0d xi=%0d cnt=%0d sat=%0d required min=%h max=%h mi=%0d xi=%0d cnt=%0d sat=%0d",
                   mon_got.mn, mon_got.mx, mon_got.mn_i, mon_got.mx_i, mon_got.cnt, mon_got.sat,
                   mon_exp.mn, mon_exp.mx, mon_exp.mn_i, mon_exp.mx_i, mon_exp.cnt, mon_exp.sat);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the sample transferred.
  task automatic send(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] s[$]);
    for (int i = 0; i < s.size(); i++) send(s[i], i == s.size() - 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%0b required=1", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx,
         bus.out_count, bus.out_sat} !== 58'd0) begin
      errors++; $display("FAIL reset_outputs got valid=%0b cnt=%0d min=%h required all zero",
                         bus.out_valid, bus.out_count, bus.out_min);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] q[$];
    q = '{16'd5, 16'hFFFD, 16'd7, 16'hFFFD, 16'd7};
    sb.push_back(mk(16'hFFFD, 16'h0007, 8'd1, 8'd2, 8'd5, 1'b0));
    send_frame(q);
    wait_drain();
  endtask

  task automatic test_extremes();
    logic [15:0] q[$];
    q = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
    sb.push_back(mk(16'h8000, 16'h7FFF, 8'd1, 8'd0, 8'd4, 1'b0));
    send_frame(q);
    wait_drain();
  endtask

  task automatic test_single_latency();
    sb.push_back(mk(16'h1234, 16'h1234, 8'd0, 8'd0, 8'd1, 1'b0));
    bus.in_valid = 1'b1; bus.in_data = 16'h1234; bus.in_last = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pre_valid got=%0b required=0", bus.out_valid);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency out_valid=%0b required=1", bus.out_valid);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] q[$];
    q = '{16'hFFFE, 16'h0003};
    bus.out_ready = 1'b0;
    sb.push_back(mk(16'hFFFE, 16'h0003, 8'd0, 8'd1, 8'd2, 1'b0));
    sb.push_back(mk(16'h0055, 16'h0055, 8'd0, 8'd0, 8'd1, 1'b0));
    send_frame(q);
    bus.in_valid = 1'b1; bus.in_data = 16'h0055; bus.in_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_handshake cycle=%0d out_valid=%0b in_ready=%0b required 1/0",
                           c, bus.out_valid, bus.in_ready);
      end
      checks++;
      if ({bus.out_min, bus.out_max, bus.out_min_idx, bus.out_max_idx, bus.out_count, bus.out_sat}
          !== {16'hFFFE, 16'h0003, 8'd0, 8'd1, 8'd2, 1'b0}) begin
        errors++; $display("FAIL stall_record cycle=%0d min=%h max=%h cnt=%0d required FFFE/0003/2",
                           c, bus.out_min, bus.out_max, bus.out_count);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release out_valid=%0b in_ready=%0b required 0/1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL next_accept out_valid=%0b required=1", bus.out_valid);
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    sb.push_back(mk(16'h0000, 16'h0001, 8'd255, 8'd0, 8'd255, 1'b1));
    for (int i = 1; i <= 300; i++) send((i == 280) ? 16'h0000 : 16'h0001, i == 300);
    wait_drain();
  endtask

  task automatic test_clear();
    send(16'd2, 1'b0);
    send(16'd9, 1'b0);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'd100; bus.in_last = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_count !== 8'd0) begin
      errors++; $display("FAIL clear_frame in_ready=%0b out_valid=%0b cnt=%0d required 1/0/0",
                         bus.in_ready, bus.out_valid, bus.out_count);
    end
    sb.push_back(mk(16'd4, 16'd4, 8'd0, 8'd0, 8'd1, 1'b0));
    send(16'd4, 1'b1);
    wait_drain();
    // Pending report dropped by clear
    bus.out_ready = 1'b0;
    send(16'h0011, 1'b1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_count !== 8'd0) begin
      errors++; $display("FAIL clear_report out_valid=%0b in_ready=%0b cnt=%0d required 0/1/0",
                         bus.out_valid, bus.in_ready, bus.out_count);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send(16'h0003, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_count !== 8'd0) begin
      errors++; $display("FAIL async_reset out_valid=%0b in_ready=%0b cnt=%0d required 0/1/0",
                         bus.out_valid, bus.in_ready, bus.out_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    // Reset mid-frame
    send(16'h0008, 1'b0);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back(mk(16'hFFFB, 16'hFFFB, 8'd0, 8'd0, 8'd1, 1'b0));
    send(16'hFFFB, 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    int len;
    logic [15:0] v;
    for (int f = 0; f < 6; f++) begin
      q = {};
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 5))
          0: v = 16'h8000;
          1: v = 16'h7FFF;
          2: v = 16'hFFFF;
          default: v = 16'($urandom);
        endcase
        q.push_back(v);
      end
      sb.push_back(model(q));
      send_frame(q);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_single_latency();
    test_backpressure();
    test_saturation();
    test_clear();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL leftover_records got=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
